// File: rtl/adder_pkg.sv
// Shared constants for the adder32_bit block: default operand width and
// carry-lookahead group size.
package adder_pkg;

  localparam int ADDER_W = 32;
  localparam int CLA_GRP = 4;

endpackage

// File: rtl/adder32_bit_cla4.sv
// cla4: 4-bit carry-lookahead adder slice; all four carries come from
// generate/propagate terms rather than rippling through the slice.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/adder32_bit.sv
// adder32_bit: registered N-bit adder built from cla4 groups with ripple carry
// between groups. Define ADDER32_OVF_EN to add the registered signed-overflow output Ovf.
module adder32_bit
  import adder_pkg::*;
#(
  parameter int N = ADDER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         in_valid,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         out_valid
`ifdef ADDER32_OVF_EN
  ,
  output logic         Ovf
`endif
);

  localparam int NG = N / CLA_GRP;

  logic [NG:0]  carry;
  logic [N-1:0] sum_d;
  logic [N-1:0] sum_q;
  logic         cout_q;
  logic         valid_q;

  assign carry[0] = Cin;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    cla4 u_cla4 (
      .a  (A[g*CLA_GRP +: CLA_GRP]),
      .b  (B[g*CLA_GRP +: CLA_GRP]),
      .ci (carry[g]),
      .s  (sum_d[g*CLA_GRP +: CLA_GRP]),
      .co (carry[g+1])
    );
  end

  // Result registers only load on valid edges; out_valid tracks in_valid directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= carry[NG];
      end
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = valid_q;

`ifdef ADDER32_OVF_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (A[N-1] == B[N-1]) && (sum_d[N-1] != A[N-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder32_bit.sv
// Self-checking bench for adder32_bit: directed corner cases, asynchronous
// reset behaviour and randomized traffic against an arithmetic reference model.
module tb_adder32_bit;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         in_valid;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         out_valid;
`ifdef ADDER32_OVF_EN
  logic         Ovf;
`endif

  adder32_bit #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .Sum       (Sum),
    .Cout      (Cout),
    .out_valid (out_valid)
`ifdef ADDER32_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the outputs should show right now.
  logic [N-1:0] m_sum;
  logic         m_cout;
  logic         m_valid;
  logic         m_ovf;

  task automatic model_reset();
    m_sum   = '0;
    m_cout  = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Plain wide arithmetic: unsigned sum for {Cout,Sum}, signed range test for overflow.
  task automatic model_edge(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic cin, input logic v);
    logic [N:0] wide;
    longint     sa, sb, ssum;
    m_valid = v;
    if (v) begin
      wide   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      m_sum  = wide[N-1:0];
      m_cout = wide[N];
      sa     = longint'($signed(a));
      sb     = longint'($signed(b));
      ssum   = sa + sb + longint'(cin);
      m_ovf  = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    end
  endtask

  task automatic check(input string tag);
    n_checks++;
    assert (Sum === m_sum) else begin
      n_fail++;
      $error("FAIL %s Sum: observed %h expected %h", tag, Sum, m_sum);
    end
    n_checks++;
    assert (Cout === m_cout) else begin
      n_fail++;
      $error("FAIL %s Cout: observed %b expected %b", tag, Cout, m_cout);
    end
    n_checks++;
    assert (out_valid === m_valid) else begin
      n_fail++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, m_valid);
    end
`ifdef ADDER32_OVF_EN
    n_checks++;
    assert (Ovf === m_ovf) else begin
      n_fail++;
      $error("FAIL %s Ovf: observed %b expected %b", tag, Ovf, m_ovf);
    end
`endif
  endtask

  // Drive one operand set just after an edge, clock it in, then check 1 ns later.
  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin, input logic v, input string tag);
    A = a; B = b; Cin = cin; in_valid = v;
    @(posedge clk);
    model_edge(a, b, cin, v);
    #1;
    check(tag);
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; Cin = 1'b0; in_valid = 1'b0;
    model_reset();
    #2;
    check("reset_initial");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(32'h0, 32'h0, 1'b0, 1'b0, "idle_after_reset");

    step(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, "ones_plus_zero");
    step(32'h00000000, 32'h00000000, 1'b1, 1'b1, "zero_plus_cin");
    step(32'h00000001, 32'h00000003, 1'b1, 1'b1, "one_plus_three_cin");
    step(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, "wraparound");
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, "max_case");
    step(32'h12345678, 32'h0000FFFF, 1'b0, 1'b0, "hold_invalid");
    step(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, "pos_overflow");
    step(32'h80000000, 32'h80000000, 1'b0, 1'b1, "neg_overflow");

    // Asynchronous reset mid-cycle discards the freshly loaded result.
    step(32'h00000001, 32'h00000003, 1'b1, 1'b1, "pre_reset_load");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_immediate");
    @(negedge clk);
    reset = 1'b0;
    step(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, "post_reset_idle");
    step(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, "post_reset_resume");
    step(32'h0, 32'h0, 1'b0, 1'b0, "post_resume_hold");

    for (int i = 0; i < 300; i++) begin
      step($urandom, $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder32_bit.md
ADDER32_BIT -- requirements
Module: adder32_bit

Interface
REQ-001 The block SHALL have parameter N, default 32, operand width in bits; legal values are multiples of 4, from 4 to 64.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 A  input  N  addend A, unsigned or two's complement.
REQ-006 B  input  N  addend B.
REQ-007 Cin  input  1  carry into bit 0.
REQ-008 in_valid  input  1  A/B/Cin are valid this cycle.
REQ-009 Sum  output  N  registered sum bits.
REQ-010 Cout  output  1  registered carry out of bit N-1.
REQ-011 out_valid  output  1  Sum/Cout hold a result.
REQ-012 Ovf  output  1  registered signed overflow; present only when ADDER32_OVF_EN is defined.

Function
REQ-013 {Cout, Sum} SHALL equal A + B + Cin, computed at (N+1)-bit width with no truncation of the carry.
REQ-014 Latency SHALL be exactly 1 cycle: operands sampled on rising edge k appear on Sum/Cout after edge k.
REQ-015 When in_valid=1 on an edge, the block SHALL register Sum/Cout and set out_valid=1.
REQ-016 When in_valid=0 on an edge, Sum/Cout SHALL hold their previous values and out_valid SHALL go to 0.
REQ-017 There is no backpressure; the block SHALL accept a new operand set every cycle.
REQ-018 Addition SHALL be built from N/4 4-bit carry-lookahead groups with ripple carry between groups; no vendor adder primitives are used.
REQ-019 Wrap-around: all-ones + 0 + 1 SHALL yield Sum=0 and Cout=1.
REQ-020 Maximum case: all-ones + all-ones + 1 SHALL yield Sum=all-ones and Cout=1.
REQ-021 Combinational logic SHALL contain no latches, and outputs SHALL never be X after reset.

Reset
REQ-022 While reset=1, the block SHALL immediately force Sum=0, Cout=0, out_valid=0 and Ovf=0, independent of clk.
REQ-023 An operation whose reset asserts between sampling and output SHALL be discarded; after release the block SHALL resume on the first edge with in_valid=1.

Configuration
REQ-024 With macro ADDER32_OVF_EN defined, the block SHALL expose Ovf, registered alongside Sum.
REQ-025 Ovf SHALL equal (A[N-1]==B[N-1]) && (Sum[N-1]!=A[N-1]).
REQ-026 Without ADDER32_OVF_EN, there SHALL be no Ovf port and no overflow logic.

Structure
REQ-027 A shared package adder_pkg SHALL hold the default width constant ADDER_W=32 and the group-size constant CLA_GRP=4.
REQ-028 The block SHALL use one sub-module, cla4: 4-bit carry-lookahead adder with ports a[3:0], b[3:0], ci, s[3:0], co, instantiated N/4 times by a generate loop.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- A=FFFFFFFF, B=00000000, Cin=0, in_valid=1 -> next cycle Sum=FFFFFFFF, Cout=0, out_valid=1.
- A=00000000, B=00000000, Cin=1 -> Sum=00000001, Cout=0.
- A=00000001, B=00000003, Cin=1 -> Sum=00000005, Cout=0.
- A=FFFFFFFF, B=00000000, Cin=1 -> Sum=00000000, Cout=1; and A=FFFFFFFF, B=FFFFFFFF, Cin=1 -> Sum=FFFFFFFF, Cout=1.
- Assert reset asynchronously mid-cycle after loading 1+3+1 -> Sum=0, Cout=0, out_valid=0 immediately, before the next edge; in_valid=0 cycle -> Sum held, out_valid=0.
- With ADDER32_OVF_EN: A=7FFFFFFF, B=00000001, Cin=0 -> Sum=80000000, Ovf=1, Cout=0.
